ifetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register; consumes the current fetch PC and issues word reads to instruction memory.
- Tracks outstanding requests and reorders nothing: returned words are presented to decode in program order, each tagged with its PC.
- Back-pressures the PC/NPC path through pc_ready_o.
- flush_i (branch/jump redirect) discards every queued and in-flight fetch.

---
 rtl/ifetch_queue.sv | 133 +++++++++++++
 tb/tb_ifetch_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch queue between the PC stage and decode.
// Optional IFETCH_MISALIGN_EXC_EN: misaligned PCs allocate a pre-filled NOP entry flagged misaligned.
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
`ifdef IFETCH_MISALIGN_EXC_EN
    output logic        inst_misalign_o,
`endif
    output logic [31:0] inst_pc_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] pend, vld;
    logic [AW:0]      alloc_ptr, fill_ptr, rd_ptr, fill_start, fill_next, probe, count, pend_cnt;
    logic [AW-1:0]    fill_idx;
    logic [7:0]       discard_cnt, dsum;
    logic             full, misal, alloc, fill, pop, any_pend;

    assign count        = alloc_ptr - rd_ptr;
    assign full         = count == (AW+1)'(DEPTH);
`ifdef IFETCH_MISALIGN_EXC_EN
    logic [DEPTH-1:0] mis;
    assign misal           = pc_i[1:0] != 2'b00;
    assign fill_start      = rd_ptr;
    assign inst_misalign_o = mis[rd_ptr[AW-1:0]];
`else
    assign misal      = 1'b0;
    assign fill_start = fill_ptr;
`endif
    assign imem_req_o   = rst_n & pc_valid_i & ~full & ~flush_i & ~misal;
    assign pc_ready_o   = rst_n & pc_valid_i & ~full & ~flush_i & (misal | imem_gnt_i);
    assign imem_addr_o  = {pc_i[31:2], 2'b00};
    assign alloc        = pc_ready_o;
    assign inst_valid_o = vld[rd_ptr[AW-1:0]] & ~pend[rd_ptr[AW-1:0]];
    assign inst_o       = data_q[rd_ptr[AW-1:0]];
    assign inst_pc_o    = pc_q[rd_ptr[AW-1:0]];
    assign pop          = inst_valid_o & inst_ready_i & ~flush_i;
    assign fill         = imem_rvalid_i & (discard_cnt == 8'd0) & any_pend & ~flush_i;
    assign dsum         = discard_cnt + 8'(pend_cnt);

    // Oldest pending entry: scan descending so the nearest offset wins.
    always_comb begin
        fill_idx  = fill_start[AW-1:0];
        fill_next = fill_start + (AW+1)'(1);
        probe     = fill_start;
        any_pend  = 1'b0;
        pend_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            probe = fill_start + (AW+1)'(i);
            if (pend[probe[AW-1:0]]) begin
                fill_idx  = probe[AW-1:0];
                fill_next = probe + (AW+1)'(1);
                any_pend  = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) pend_cnt = pend_cnt + (AW+1)'(pend[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            discard_cnt <= '0;
            pend        <= '0;
            vld         <= '0;
`ifdef IFETCH_MISALIGN_EXC_EN
            mis         <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (flush_i) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            pend        <= '0;
            vld         <= '0;
`ifdef IFETCH_MISALIGN_EXC_EN
            mis         <= '0;
`endif
            // A response arriving with the flush already retires one of the orphans.
            discard_cnt <= dsum - 8'((imem_rvalid_i && dsum != 8'd0) ? 1 : 0);
        end else begin
            if (imem_rvalid_i && discard_cnt != 8'd0) discard_cnt <= discard_cnt - 8'd1;
            if (alloc) begin
                pc_q[alloc_ptr[AW-1:0]] <= pc_i;
                vld[alloc_ptr[AW-1:0]]  <= 1'b1;
                pend[alloc_ptr[AW-1:0]] <= ~misal;
`ifdef IFETCH_MISALIGN_EXC_EN
                mis[alloc_ptr[AW-1:0]]  <= misal;
                if (misal) data_q[alloc_ptr[AW-1:0]] <= 32'h0000_0013;
`endif
                alloc_ptr <= alloc_ptr + (AW+1)'(1);
            end
            if (fill) begin
                data_q[fill_idx] <= imem_rdata_i;
                pend[fill_idx]   <= 1'b0;
                fill_ptr         <= fill_next;
            end
            if (pop) begin
                vld[rd_ptr[AW-1:0]] <= 1'b0;
`ifdef IFETCH_MISALIGN_EXC_EN
                mis[rd_ptr[AW-1:0]] <= 1'b0;
`endif
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && imem_rvalid_i)
            assert (discard_cnt != 8'd0 || pend != '0)
            else $error("ifetch_queue: read data with nothing outstanding");
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed stimulus with a queue-level model of program-order fetch delivery.
module tb_ifetch_queue;
    localparam int DEPTH = 4;
`ifdef IFETCH_MISALIGN_EXC_EN
    localparam logic [31:0] LOW = 32'h0;
`else
    localparam logic [31:0] LOW = 32'h2;
`endif

    logic        clk = 0, rst_n = 1;
    logic [31:0] pc = 0;
    logic        pc_valid = 0, pc_ready, flush = 0, imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1, imem_rvalid = 0;
    logic [31:0] imem_rdata = 0;
    logic        inst_valid, inst_ready = 1;
    logic [31:0] inst, inst_pc;
    logic        mis;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready),
        .flush_i(flush), .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata), .inst_valid_o(inst_valid),
        .inst_ready_i(inst_ready), .inst_o(inst),
`ifdef IFETCH_MISALIGN_EXC_EN
        .inst_misalign_o(mis),
`endif
        .inst_pc_o(inst_pc)
    );
`ifndef IFETCH_MISALIGN_EXC_EN
    assign mis = 1'b0;
`endif

    typedef struct { logic [31:0] pc; logic [31:0] data; logic mis; logic arr; } ent_t;
    typedef struct { logic [31:0] a; int due; logic keep; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic mis; int c; } log_t;

    ent_t  exp_q[$];
    mreq_t mem_q[$];
    log_t  log_q[$];
    int    gcyc_q[$];
    int    vectors = 0, errs = 0, cyc = 0, ngr = 0, nreq = 0;
    logic  mem_hold = 0, rsp_keep = 0;
    logic  er, erdy, ev, found, ma;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00500093;
            32'h4:   return 32'h00a00113;
            32'h8:   return 32'h002081b3;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    function automatic logic misa(input logic [31:0] p);
`ifdef IFETCH_MISALIGN_EXC_EN
        return p[1:0] != 2'b00;
`else
        return p[0] & 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Model: every accepted PC is delivered once, in order, unless flushed or reset away.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", inst_valid, 0);
            chk("rst_req", imem_req, 0);
            chk("rst_ready", pc_ready, 0);
            chk("rst_inst", inst, 0);
            chk("rst_inst_pc", inst_pc, 0);
            exp_q.delete();
            mem_q.delete();
        end else begin
            ma   = misa(pc);
            er   = pc_valid && exp_q.size() < DEPTH && !flush && !ma;
            erdy = pc_valid && exp_q.size() < DEPTH && !flush && (ma || imem_gnt);
            ev   = exp_q.size() > 0 && exp_q[0].arr;
            chk("imem_req", imem_req, er);
            if (er) chk("imem_addr", imem_addr, {pc[31:2], 2'b00});
            chk("pc_ready", pc_ready, erdy);
            chk("inst_valid", inst_valid, ev);
            if (ev) begin
                chk("inst", inst, exp_q[0].data);
                chk("inst_pc", inst_pc, exp_q[0].pc);
`ifdef IFETCH_MISALIGN_EXC_EN
                chk("inst_misalign", mis, exp_q[0].mis);
`endif
            end
            if (imem_req && imem_gnt) nreq++;
            if (flush) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].keep = 0;
            end else begin
                if (imem_rvalid && rsp_keep) begin
                    found = 0;
                    foreach (exp_q[i]) if (!found && !exp_q[i].arr) begin
                        exp_q[i].arr = 1;
                        found = 1;
                    end
                    if (!found) begin
                        errs++;
                        $display("FAIL rsp_owner: response with no model entry at cycle %0d", cyc);
                    end
                end
                if (ev && inst_ready) begin
                    log_q.push_back('{pc: inst_pc, data: inst, mis: mis, c: cyc});
                    exp_q.delete(0);
                end
                if (erdy) begin
                    exp_q.push_back('{pc: pc, data: ma ? 32'h13 : memf({pc[31:2], 2'b00}), mis: ma, arr: ma});
                    if (!ma) mem_q.push_back('{a: {pc[31:2], 2'b00}, due: cyc + 1, keep: 1'b1});
                    ngr++;
                    gcyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic mem_drive();
        imem_rvalid = 0;
        rsp_keep    = 0;
        if (rst_n && !mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1;
            imem_rdata  = memf(mem_q[0].a);
            rsp_keep    = mem_q[0].keep;
            mem_q.delete(0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        mem_drive();
    endtask

    task automatic wait_pops(input int n);
        int t = 0;
        while (log_q.size() < n && t < 40) begin
            tick();
            t++;
        end
        if (log_q.size() < n) begin
            errs++;
            $display("FAIL wait_pops: got %0d pops want %0d", log_q.size(), n);
        end
    endtask

    task automatic drain();
        int t = 0;
        pc_valid   = 0;
        inst_ready = 1;
        mem_hold   = 0;
        while ((exp_q.size() > 0 || mem_q.size() > 0) && t < 40) begin
            tick();
            t++;
        end
        if (exp_q.size() > 0 || mem_q.size() > 0) begin
            errs++;
            $display("FAIL drain: %0d entries %0d requests left", exp_q.size(), mem_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] b2b_d [3];
        int n0;
        b2b_d = '{32'h00500093, 32'h00a00113, 32'h002081b3};
        #1 rst_n = 0;
        pc = 32'h40; pc_valid = 1;
        tick(); tick();
        pc_valid = 0; rst_n = 1;
        tick();

        // back-to-back fetch, one-cycle memory
        log_q.delete(); gcyc_q.delete();
        pc = 32'h0; pc_valid = 1; tick();
        pc = 32'h4; tick();
        pc = 32'h8; tick();
        pc_valid = 0;
        wait_pops(3);
        if (log_q.size() >= 3 && gcyc_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("b2b_pc", log_q[i].pc, 32'(i * 4));
                chk("b2b_data", log_q[i].data, b2b_d[i]);
            end
            chk("b2b_latency", 32'(log_q[0].c - gcyc_q[0]), 2);
            chk("b2b_grant_span", 32'(gcyc_q[2] - gcyc_q[0]), 2);
        end
        drain();

        // fill the queue with decode stalled
        inst_ready = 0; ngr = 0; pc_valid = 1;
        repeat (8) begin pc = 32'h200 + 32'(4 * ngr); tick(); end
        chk("full_grants", ngr, 4);
        chk("full_req", imem_req, 0);
        chk("full_ready", pc_ready, 0);
        inst_ready = 1; tick();
        inst_ready = 0;
        repeat (3) begin pc = 32'h200 + 32'(4 * ngr); tick(); end
        chk("full_refill", ngr, 5);
        drain();

        // flush with three outstanding, one response landing with the flush
        log_q.delete();
        mem_hold = 1; pc_valid = 1;
        pc = 32'h20; tick();
        pc = 32'h24; tick();
        pc = 32'h28; tick();
        pc_valid = 0; tick();
        mem_hold = 0; mem_drive(); mem_hold = 1; flush = 1;
        tick();
        flush = 0; pc = 32'h100; pc_valid = 1;
        tick();
        pc_valid = 0; mem_hold = 0;
        wait_pops(1);
        repeat (6) tick();
        chk("flush_pops", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("flush_pc", log_q[0].pc, 32'h100);
            chk("flush_data", log_q[0].data, 32'h0100feff);
        end
        drain();

        // memory refuses grants for five cycles
        log_q.delete();
        imem_gnt = 0; pc = 32'h300 | LOW; pc_valid = 1; n0 = ngr;
        repeat (5) begin
            tick();
            chk("stall_addr", imem_addr, 32'h300);
            chk("stall_ready", pc_ready, 0);
        end
        chk("stall_grants", 32'(ngr - n0), 0);
        imem_gnt = 1; tick();
        pc_valid = 0;
        wait_pops(1);
        if (log_q.size() >= 1) chk("stall_tag", log_q[0].pc, 32'h300 | LOW);
        drain();

        // reset with three instructions buffered
        log_q.delete();
        inst_ready = 0; pc_valid = 1;
        pc = 32'h400; tick();
        pc = 32'h404; tick();
        pc = 32'h408; tick();
        pc_valid = 0;
        repeat (3) tick();
        rst_n = 0; pc = 32'h500; pc_valid = 1;
        #1;
        chk("midrst_valid", inst_valid, 0);
        chk("midrst_req", imem_req, 0);
        tick();
        rst_n = 1; pc = 32'h0; inst_ready = 1;
        tick();
        pc_valid = 0;
        wait_pops(1);
        if (log_q.size() >= 1) begin
            chk("midrst_first_pc", log_q[0].pc, 32'h0);
            chk("midrst_first_data", log_q[0].data, 32'h00500093);
        end
        drain();

`ifdef IFETCH_MISALIGN_EXC_EN
        // misaligned PC between two aligned ones
        log_q.delete(); n0 = nreq;
        pc_valid = 1;
        pc = 32'h0; tick();
        pc = 32'h6; tick();
        pc = 32'h8; tick();
        pc_valid = 0;
        wait_pops(3);
        if (log_q.size() >= 3) begin
            chk("mis_pc0", log_q[0].pc, 32'h0);
            chk("mis_pc1", log_q[1].pc, 32'h6);
            chk("mis_pc2", log_q[2].pc, 32'h8);
            chk("mis_data1", log_q[1].data, 32'h13);
            chk("mis_flag0", log_q[0].mis, 0);
            chk("mis_flag1", log_q[1].mis, 1);
        end
        chk("mis_reqs", 32'(nreq - n0), 2);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
